bus_controller: RTL and testbench

- Hardwired control unit for the 16-bit common-bus CPU datapath (AC, DR, IR, AR, PC, TR, memory).
- Runs a timing sequence counter T0..T6 and a run/halt state machine.
- Drives the bus source select, per-register load/increment/clear strobes, memory read/write and the ALU op.
- Executes fetch, decode, indirect, memory-reference and register-reference instructions.

---
 rtl/bus_controller.sv | 216 +++++++++++++++++++++
 tb/tb_bus_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_controller.sv
// bus_controller: hardwired control unit for the 16-bit common-bus CPU.
// It steps a T0..T6 timing counter under an IDLE/RUN/HALT mode machine and decodes
// the instruction into bus-select, register-strobe, memory and ALU controls.
// Optional feature macro: CTRL_SINGLE_STEP_EN adds a step input and a PAUSE mode
// that stops after every instruction until step is pulsed.
module bus_controller #(
  parameter int WORD_W  = 16,
  parameter int IO_HALT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [WORD_W-1:0] ir_in,
  input  logic              dr_zero,
  input  logic              ac_zero,
  input  logic              ac_neg,
  output logic [2:0]        bus_sel,
  output logic              ld_ar,
  output logic              inc_ar,
  output logic              ld_pc,
  output logic              inc_pc,
  output logic              ld_dr,
  output logic              inc_dr,
  output logic              ld_ac,
  output logic              inc_ac,
  output logic              clr_ac,
  output logic              ld_ir,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        alu_op,
  output logic [2:0]        seq_t,
  output logic              instr_done,
  output logic              halted
);

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_HALT  = 2'd2;
  localparam logic [1:0] MODE_PAUSE = 2'd3;

  logic [1:0] r_mode;
  logic [2:0] r_sc;
  logic       r_i;
  logic [2:0] r_d;
  logic       w_done;
  logic       w_haltReq;
  logic       w_unused;

  // IR bits that decode to NOP for register-reference instructions.
  assign w_unused = &{1'b0, ir_in[10], ir_in[8:6], ir_in[1]};

  assign instr_done = w_done;
  assign seq_t      = (r_mode == MODE_RUN) ? r_sc : 3'd0;
  assign halted     = (r_mode == MODE_HALT);

  // Decode timing step, latched opcode fields and flags into this cycle's controls.
  always_comb begin
    bus_sel   = 3'd0;
    ld_ar     = 1'b0;
    inc_ar    = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    ld_dr     = 1'b0;
    inc_dr    = 1'b0;
    ld_ac     = 1'b0;
    inc_ac    = 1'b0;
    clr_ac    = 1'b0;
    ld_ir     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_op    = 3'd0;
    w_done    = 1'b0;
    w_haltReq = 1'b0;
    if (r_mode == MODE_RUN) begin
      case (r_sc)
        3'd0: begin
          bus_sel = 3'd2;
          ld_ar   = 1'b1;
        end
        3'd1: begin
          bus_sel  = 3'd7;
          mem_read = 1'b1;
          ld_ir    = 1'b1;
          inc_pc   = 1'b1;
        end
        3'd2: begin
          bus_sel = 3'd5;
          ld_ar   = 1'b1;
        end
        3'd3: begin
          if (r_d == 3'd7) begin
            w_done = 1'b1;
            if (!r_i) begin
              clr_ac = ir_in[11];
              if (ir_in[9]) begin
                ld_ac  = 1'b1;
                alu_op = 3'd4;
              end
              inc_ac    = ir_in[5];
              inc_pc    = (ir_in[4] & ~ac_neg) | (ir_in[3] & ac_neg) | (ir_in[2] & ac_zero);
              w_haltReq = ir_in[0];
            end else begin
              w_haltReq = (IO_HALT != 0);
            end
          end else if (r_i) begin
            bus_sel  = 3'd7;
            mem_read = 1'b1;
            ld_ar    = 1'b1;
          end
        end
        3'd4: begin
          case (r_d)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              bus_sel  = 3'd7;
              mem_read = 1'b1;
              ld_dr    = 1'b1;
            end
            3'd3: begin
              bus_sel   = 3'd4;
              mem_write = 1'b1;
              w_done    = 1'b1;
            end
            3'd4: begin
              bus_sel = 3'd1;
              ld_pc   = 1'b1;
              w_done  = 1'b1;
            end
            3'd5: begin
              bus_sel   = 3'd2;
              mem_write = 1'b1;
              inc_ar    = 1'b1;
            end
            default: ;
          endcase
        end
        3'd5: begin
          case (r_d)
            3'd0, 3'd1, 3'd2: begin
              ld_ac  = 1'b1;
              alu_op = r_d + 3'd1;
              w_done = 1'b1;
            end
            3'd5: begin
              bus_sel = 3'd1;
              ld_pc   = 1'b1;
              w_done  = 1'b1;
            end
            3'd6: inc_dr = 1'b1;
            default: ;
          endcase
        end
        3'd6: begin
          if (r_d == 3'd6) begin
            bus_sel   = 3'd3;
            mem_write = 1'b1;
            inc_pc    = dr_zero;
            w_done    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Mode machine, timing counter and opcode-field latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode <= MODE_IDLE;
      r_sc   <= 3'd0;
      r_i    <= 1'b0;
      r_d    <= 3'd0;
    end else begin
      case (r_mode)
        MODE_IDLE: begin
          r_sc <= 3'd0;
          if (run) r_mode <= MODE_RUN;
        end
        MODE_RUN: begin
          if (r_sc == 3'd2) begin
            r_i <= ir_in[15];
            r_d <= ir_in[14:12];
          end
          if (w_done) begin
            r_sc <= 3'd0;
            if (w_haltReq) r_mode <= MODE_HALT;
            else if (!run) r_mode <= MODE_IDLE;
`ifdef CTRL_SINGLE_STEP_EN
            else r_mode <= MODE_PAUSE;
`endif
          end else begin
            r_sc <= r_sc + 3'd1;
          end
        end
        MODE_HALT: begin
          r_sc <= 3'd0;
          if (!run) r_mode <= MODE_IDLE;
        end
`ifdef CTRL_SINGLE_STEP_EN
        MODE_PAUSE: begin
          r_sc <= 3'd0;
          if (!run) r_mode <= MODE_IDLE;
          else if (step) r_mode <= MODE_RUN;
        end
`endif
        default: begin
          r_mode <= MODE_IDLE;
          r_sc   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed checks of the bus_controller control sequences.
module tb_bus_controller;

  localparam logic [11:0] S_NONE  = 12'h000;
  localparam logic [11:0] S_LDAR  = 12'h800;
  localparam logic [11:0] S_INCAR = 12'h400;
  localparam logic [11:0] S_LDPC  = 12'h200;
  localparam logic [11:0] S_INCPC = 12'h100;
  localparam logic [11:0] S_LDDR  = 12'h080;
  localparam logic [11:0] S_INCDR = 12'h040;
  localparam logic [11:0] S_LDAC  = 12'h020;
  localparam logic [11:0] S_INCAC = 12'h010;
  localparam logic [11:0] S_CLRAC = 12'h008;
  localparam logic [11:0] S_LDIR  = 12'h004;
  localparam logic [11:0] S_MRD   = 12'h002;
  localparam logic [11:0] S_MWR   = 12'h001;

  logic        clock;
  logic        reset;
  logic        run;
  logic        step;
  logic [15:0] ir;
  logic        drZero;
  logic        acZero;
  logic        acNeg;
  logic [2:0]  bus_sel;
  logic        ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr;
  logic        ld_ac, inc_ac, clr_ac, ld_ir, mem_read, mem_write;
  logic [2:0]  alu_op;
  logic [2:0]  seq_t;
  logic        instr_done;
  logic        halted;

  int vectorCount;
  int miscompareCount;

  bus_controller dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
`ifdef CTRL_SINGLE_STEP_EN
    .step       (step),
`endif
    .ir_in      (ir),
    .dr_zero    (drZero),
    .ac_zero    (acZero),
    .ac_neg     (acNeg),
    .bus_sel    (bus_sel),
    .ld_ar      (ld_ar),
    .inc_ar     (inc_ar),
    .ld_pc      (ld_pc),
    .inc_pc     (inc_pc),
    .ld_dr      (ld_dr),
    .inc_dr     (inc_dr),
    .ld_ac      (ld_ac),
    .inc_ac     (inc_ac),
    .clr_ac     (clr_ac),
    .ld_ir      (ld_ir),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_op     (alu_op),
    .seq_t      (seq_t),
    .instr_done (instr_done),
    .halted     (halted)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [22:0] ex(input logic [2:0] bs, input logic [11:0] st,
                                     input logic [2:0] alu, input logic [2:0] sq,
                                     input logic dn, input logic hl);
    return {bs, st, alu, sq, dn, hl};
  endfunction

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] instr,
                               input logic dz, input logic az, input logic an);
    run    = r;
    ir     = instr;
    drZero = dz;
    acZero = az;
    acNeg  = an;
  endtask

  task automatic checkOutput(input string tag, input logic [22:0] expected);
    logic [22:0] observed;
    #1;
    observed = {bus_sel, ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, inc_ac,
                clr_ac, ld_ir, mem_read, mem_write, alu_op, seq_t, instr_done, halted};
    vectorCount++;
    assert (observed === expected)
    else begin
      miscompareCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Checks T0..T2 starting in the T0 cycle; returns in the T3 cycle.
  task automatic checkFetch(input string tag);
    checkOutput({tag, "_t0"}, ex(3'd2, S_LDAR, 3'd0, 3'd0, 1'b0, 1'b0));
    tick;
    checkOutput({tag, "_t1"}, ex(3'd7, S_MRD | S_LDIR | S_INCPC, 3'd0, 3'd1, 1'b0, 1'b0));
    tick;
    checkOutput({tag, "_t2"}, ex(3'd5, S_LDAR, 3'd0, 3'd2, 1'b0, 1'b0));
    tick;
  endtask

  // Moves from the cycle after instr_done to the next T0.
  task automatic crossBoundary(input string tag);
`ifdef CTRL_SINGLE_STEP_EN
    checkOutput({tag, "_pause"}, ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    step = 1'b1;
    tick;
    step = 1'b0;
`else
    tag = tag;
`endif
  endtask

  // Directed sequence of instructions with hand-computed control words.
  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    reset = 1'b0;
    step  = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    checkOutput("in_reset", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    tick;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      checkOutput("idle", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    end

    // ADD direct
    applyStimulus(1'b1, 16'h1123, 1'b0, 1'b0, 1'b0);
    tick;
    checkFetch("add");
    checkOutput("add_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b0, 1'b0));
    tick;
    checkOutput("add_t4", ex(3'd7, S_MRD | S_LDDR, 3'd0, 3'd4, 1'b0, 1'b0));
    tick;
    checkOutput("add_t5", ex(3'd0, S_LDAC, 3'd2, 3'd5, 1'b1, 1'b0));
    tick;
    crossBoundary("add");

    // ADD indirect
    applyStimulus(1'b1, 16'h9123, 1'b0, 1'b0, 1'b0);
    checkFetch("addi");
    checkOutput("addi_t3", ex(3'd7, S_MRD | S_LDAR, 3'd0, 3'd3, 1'b0, 1'b0));
    tick;
    checkOutput("addi_t4", ex(3'd7, S_MRD | S_LDDR, 3'd0, 3'd4, 1'b0, 1'b0));
    tick;
    checkOutput("addi_t5", ex(3'd0, S_LDAC, 3'd2, 3'd5, 1'b1, 1'b0));
    tick;
    crossBoundary("addi");

    // ISZ with the incremented word reaching zero
    applyStimulus(1'b1, 16'h6050, 1'b1, 1'b0, 1'b0);
    checkFetch("isz1");
    checkOutput("isz1_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b0, 1'b0));
    tick;
    checkOutput("isz1_t4", ex(3'd7, S_MRD | S_LDDR, 3'd0, 3'd4, 1'b0, 1'b0));
    tick;
    checkOutput("isz1_t5", ex(3'd0, S_INCDR, 3'd0, 3'd5, 1'b0, 1'b0));
    tick;
    checkOutput("isz1_t6", ex(3'd3, S_MWR | S_INCPC, 3'd0, 3'd6, 1'b1, 1'b0));
    tick;
    crossBoundary("isz1");

    // ISZ without skip
    applyStimulus(1'b1, 16'h6050, 1'b0, 1'b0, 1'b0);
    checkFetch("isz0");
    checkOutput("isz0_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b0, 1'b0));
    tick;
    checkOutput("isz0_t4", ex(3'd7, S_MRD | S_LDDR, 3'd0, 3'd4, 1'b0, 1'b0));
    tick;
    checkOutput("isz0_t5", ex(3'd0, S_INCDR, 3'd0, 3'd5, 1'b0, 1'b0));
    tick;
    checkOutput("isz0_t6", ex(3'd3, S_MWR, 3'd0, 3'd6, 1'b1, 1'b0));
    tick;
    crossBoundary("isz0");

    // CLA + SZA with AC zero
    applyStimulus(1'b1, 16'h7804, 1'b0, 1'b1, 1'b0);
    checkFetch("cla_sza");
    checkOutput("cla_sza_t3", ex(3'd0, S_CLRAC | S_INCPC, 3'd0, 3'd3, 1'b1, 1'b0));
    tick;
    crossBoundary("cla_sza");

    // CMA + INC + SPA with AC positive
    applyStimulus(1'b1, 16'h7230, 1'b0, 1'b0, 1'b0);
    checkFetch("cma_inc_spa");
    checkOutput("cma_inc_spa_t3", ex(3'd0, S_LDAC | S_INCAC | S_INCPC, 3'd4, 3'd3, 1'b1, 1'b0));
    tick;
    crossBoundary("cma_inc_spa");

    // SNA with AC positive: no skip
    applyStimulus(1'b1, 16'h7008, 1'b0, 1'b0, 1'b0);
    checkFetch("sna");
    checkOutput("sna_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b1, 1'b0));
    tick;
    crossBoundary("sna");

    // HLT
    applyStimulus(1'b1, 16'h7001, 1'b0, 1'b0, 1'b0);
    checkFetch("hlt");
    checkOutput("hlt_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b1, 1'b0));
    tick;
    checkOutput("halt_1", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b1));
    tick;
    checkOutput("halt_2", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b1));
    applyStimulus(1'b0, 16'h7001, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_run0", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b1));
    tick;
    checkOutput("halt_to_idle", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));

    // STA aborted by reset at T4
    applyStimulus(1'b1, 16'h3010, 1'b0, 1'b0, 1'b0);
    tick;
    checkFetch("sta");
    checkOutput("sta_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b0, 1'b0));
    tick;
    checkOutput("sta_t4", ex(3'd4, S_MWR, 3'd0, 3'd4, 1'b1, 1'b0));
    reset = 1'b0;
    checkOutput("sta_abort", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    applyStimulus(1'b0, 16'h3010, 1'b0, 1'b0, 1'b0);
    tick;
    reset = 1'b1;
    checkOutput("post_abort", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    tick;
    checkOutput("post_abort_idle", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));

`ifdef CTRL_SINGLE_STEP_EN
    // BUN lands in PAUSE until a step pulse
    applyStimulus(1'b1, 16'h4020, 1'b0, 1'b0, 1'b0);
    tick;
    checkFetch("bun");
    checkOutput("bun_t3", ex(3'd0, S_NONE, 3'd0, 3'd3, 1'b0, 1'b0));
    tick;
    checkOutput("bun_t4", ex(3'd1, S_LDPC, 3'd0, 3'd4, 1'b1, 1'b0));
    tick;
    checkOutput("bun_pause_1", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    tick;
    checkOutput("bun_pause_2", ex(3'd0, S_NONE, 3'd0, 3'd0, 1'b0, 1'b0));
    step = 1'b1;
    tick;
    step = 1'b0;
    checkOutput("step_t0", ex(3'd2, S_LDAR, 3'd0, 3'd0, 1'b0, 1'b0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
